// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
//   3-to-8 line decoder with enable, for small address/select decoding.
//   While enabled, exactly one of the eight lines is active for the 3-bit
//   select code. While disabled or in reset, no line is active.
//
// Parameters
//   OUT_REG     1: D is registered (1-cycle latency)
//               0: D is combinational from a/en (0-cycle latency)
//   ACTIVE_LOW  1: D is inverted after decode (selected line low, all others high)
//
// Ports
//   clk    in   1  rising-edge clock (used only when OUT_REG=1)
//   rst_n  in   1  synchronous active-low reset; forces the inactive value
//   en     in   1  decode enable, active high
//   a      in   3  select code, a[2] is the MSB
//   D      out  8  decoded lines; D[i] corresponds to a == i
//
// Configuration
//   DECODER_3TO8_HOLD_EN (OUT_REG=1 only): when defined, the output register
//   holds its last value while en==0 instead of clearing. Reset still clears
//   it. The macro has no effect when OUT_REG=0.
// -----------------------------------------------------------------------------
module decoder_3to8 #(
   parameter bit OUT_REG    = 1'b1,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] a,
   output logic [7:0] D
);

   // Active-high decode of the current inputs; en dominates a.
   logic [7:0] dec;
   // Active-high decoded value after reset/registering, before polarity.
   logic [7:0] dec_out;

   always_comb begin
      dec = 8'h00;
      if (en) begin
         dec[a] = 1'b1;
      end
   end

   generate
      if (OUT_REG) begin : g_reg
         logic [7:0] dec_q;

         // Reset dominates en. The register output only ever takes a
         // one-hot or all-zero value, so D cannot glitch between edges.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               dec_q <= 8'h00;
`ifdef DECODER_3TO8_HOLD_EN
            end else if (en) begin
               dec_q <= dec;
            end
`else
            end else begin
               dec_q <= dec;
            end
`endif
         end

         assign dec_out = dec_q;
      end else begin : g_comb
         // Reset still forces the inactive value, but without waiting for a clock.
         assign dec_out = rst_n ? dec : 8'h00;
      end
   endgenerate

   // Polarity is applied last so reset yields 8'h00 or 8'hFF accordingly.
   assign D = ACTIVE_LOW ? ~dec_out : dec_out;

endmodule

// File: tb/tb_decoder_3to8.sv
module tb_decoder_3to8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] a;
  logic [7:0] d_main;
  logic [7:0] d_low;

  logic       comb_rst_n;
  logic       comb_en;
  logic [2:0] comb_a;
  logic [7:0] d_comb;

  int unsigned n_total = 0;
  int unsigned n_fail  = 0;

  // reference model state for the registered instances (active-high view)
  logic [7:0] model_q;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  decoder_3to8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .D(d_main)
  );

  decoder_3to8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .D(d_low)
  );

  decoder_3to8 #(.OUT_REG(1'b0), .ACTIVE_LOW(1'b0)) u_comb (
    .clk(clk), .rst_n(comb_rst_n), .en(comb_en), .a(comb_a), .D(d_comb)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] line_of(input logic [2:0] sel);
    logic [7:0] v;
    v = 8'(2 ** int'(sel));
    return v;
  endfunction

  function automatic logic [7:0] model_next(input logic r, input logic e,
                                            input logic [2:0] sel,
                                            input logic [7:0] prev);
    if (!r) return 8'h00;
    if (e)  return line_of(sel);
`ifdef DECODER_3TO8_HOLD_EN
    return prev;
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs on the falling edge, let one rising edge pass, check #1 later.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] sel);
    @(negedge clk);
    rst_n = r;
    en    = e;
    a     = sel;
    model_q = model_next(r, e, sel, model_q);
    @(posedge clk);
    #1;
    check({tag, "_hi"}, d_main, model_q);
    check({tag, "_lo"}, d_low, ~model_q);
  endtask

  task automatic comb_step(input string tag, input logic r, input logic e, input logic [2:0] sel);
    comb_rst_n = r;
    comb_en    = e;
    comb_a     = sel;
    #1;
    check(tag, d_comb, (r && e) ? line_of(sel) : 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] hold_val;
    rst_n = 1'b0; en = 1'b1; a = 3'b101;
    comb_rst_n = 1'b0; comb_en = 1'b0; comb_a = 3'b000;
    model_q = 8'h00;

    // reset held for two cycles with an active request
    step("rst0", 1'b0, 1'b1, 3'b101);
    step("rst1", 1'b0, 1'b1, 3'b101);
    check("rst_fixed_lo", d_low, 8'hFF);
    step("rel", 1'b1, 1'b1, 3'b101);
    check("rel_fixed", d_main, 8'h20);

    // disabled
    step("dis0", 1'b1, 1'b0, 3'b000);
    step("dis3", 1'b1, 1'b0, 3'b011);

    // successive selects
    step("s1", 1'b1, 1'b1, 3'b001);
    check("s1_fixed", d_main, 8'h02);
    step("s5", 1'b1, 1'b1, 3'b101);
    check("s5_fixed", d_main, 8'h20);
    step("s7", 1'b1, 1'b1, 3'b111);
    check("s7_fixed", d_main, 8'h80);

    // disable after 111 then re-enable on 100
    hold_val = 8'h80;
    step("dis4", 1'b1, 1'b0, 3'b100);
`ifdef DECODER_3TO8_HOLD_EN
    check("dis4_fixed", d_main, hold_val);
`else
    check("dis4_fixed", d_main, 8'h00);
`endif
    step("en4", 1'b1, 1'b1, 3'b100);
    check("en4_fixed", d_main, 8'h10);

    // full sweep, one line set each time
    for (int i = 0; i < 8; i++) begin
      step("sweep", 1'b1, 1'b1, 3'(i));
      check("sweep_count", 8'($countones(d_main)), 8'd1);
    end

    // mid-operation reset
    step("mid_rst", 1'b0, 1'b1, 3'b010);
    check("mid_rst_lo", d_low, 8'hFF);

    // randomized traffic, occasional reset
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    // combinational instance: no clock edge involved
    @(negedge clk);
    comb_step("comb_rst", 1'b0, 1'b1, 3'b110);
    comb_step("comb_a6", 1'b1, 1'b1, 3'b110);
    check("comb_a6_fixed", d_comb, 8'h40);
    comb_step("comb_rst_now", 1'b0, 1'b1, 3'b110);
    check("comb_rst_fixed", d_comb, 8'h00);
    comb_step("comb_dis", 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 30; i++) begin
      comb_step("comb_rand", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
